// File: rtl/dmem_resp_router_pkg.sv
// rtl/dmem_resp_router_pkg.sv - shared defaults, load funct3 encodings and tag layout for dmem_resp_router
package dmem_resp_router_pkg;
  localparam int DEF_NCORES     = 4;
  localparam int DEF_DMEM_ADDRW = 16;
  localparam int F3_W           = 3;
  localparam int BOFF_W         = 2;

  typedef enum logic [F3_W-1:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

  typedef struct packed {
    logic              we;
    logic [F3_W-1:0]   funct3;
    logic [BOFF_W-1:0] boff;
  } acc_t;

  localparam int ACC_W = $bits(acc_t);

  function automatic int sel_width(input int ncores);
    return (ncores == 1) ? 1 : $clog2(ncores);
  endfunction
endpackage

// File: rtl/dmem_resp_router_tag_pipe.sv
// rtl/dmem_resp_router_tag_pipe.sv - resp_tag_pipe: DEPTH-stage {valid, tag} shift pipeline
// The owner core index occupies the SELW most significant tag bits and is exposed per stage.
module resp_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int TAGW  = 8,
  parameter int SELW  = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  input  logic [TAGW-1:0]       in_tag_i,
  output logic [DEPTH-1:0]      valid_o,
  output logic [DEPTH*SELW-1:0] sel_o,
  output logic                  tail_valid_o,
  output logic [TAGW-1:0]       tail_tag_o
);
  logic [DEPTH-1:0] valid_q;
  logic [TAGW-1:0]  tag_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
    end else begin
      valid_q[0] <= in_valid_i;
      tag_q[0]   <= in_tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    sel_o = '0;
    for (int i = 0; i < DEPTH; i++) sel_o[i*SELW +: SELW] = tag_q[i][TAGW-1 -: SELW];
  end

  assign valid_o      = valid_q;
  assign tail_valid_o = valid_q[DEPTH-1];
  assign tail_tag_o   = tag_q[DEPTH-1];
endmodule

// File: rtl/dmem_resp_router.sv
// rtl/dmem_resp_router.sv - DMEM return path: per-lane tag pipes, response demux, busy and sticky error
// Optional RESP_LOAD_EXT_EN: router aligns and sign/zero-extends load data instead of returning the raw word.
module dmem_resp_router
  import dmem_resp_router_pkg::*;
#(
  parameter int  NCORES      = DEF_NCORES,
  parameter int  ADDR_WIDTH  = DEF_DMEM_ADDRW,
  parameter int  DATA_WIDTH  = 32,
  parameter int  MEM_LATENCY = 1,
  localparam int SELW        = sel_width(NCORES)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         issue_a_valid_i,
  input  logic [SELW-1:0]              issue_a_sel_i,
  input  logic                         issue_a_we_i,
  input  logic [2:0]                   issue_a_funct3_i,
  input  logic [1:0]                   issue_a_boff_i,
  input  logic                         issue_b_valid_i,
  input  logic [SELW-1:0]              issue_b_sel_i,
  input  logic                         issue_b_we_i,
  input  logic [2:0]                   issue_b_funct3_i,
  input  logic [1:0]                   issue_b_boff_i,
  input  logic [DATA_WIDTH-1:0]        mem_rdata_a_i,
  input  logic [DATA_WIDTH-1:0]        mem_rdata_b_i,
  output logic [NCORES-1:0]            rsp_valid_o,
  output logic [NCORES*DATA_WIDTH-1:0] rsp_rdata_packed_o,
  output logic [NCORES-1:0]            busy_o,
  output logic                         err_o
);
  localparam int TAGW = SELW + ACC_W;

  logic [NCORES-1:0]            oh_a, oh_b, toh_a, toh_b, busy;
  logic [NCORES-1:0]            rsp_valid_q, rsp_valid_d;
  logic [NCORES*DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                         err_q, err_d;
  logic                         ok_a, ok_b, collide, cap_a, cap_b;
  logic [MEM_LATENCY-1:0]       pv_a, pv_b;
  logic [MEM_LATENCY*SELW-1:0]  ps_a, ps_b;
  logic                         tail_v_a, tail_v_b;
  logic [TAGW-1:0]              tail_tag_a, tail_tag_b;
  logic [SELW-1:0]              tail_sel_a, tail_sel_b;
  acc_t                         acc_a, acc_b, tail_acc_a, tail_acc_b;
  logic [DATA_WIDTH-1:0]        resp_a, resp_b;
  logic [ADDR_WIDTH-1:0]        unused_addr;

  assign unused_addr = '0;
  assign acc_a = '{we: issue_a_we_i, funct3: issue_a_funct3_i, boff: issue_a_boff_i};
  assign acc_b = '{we: issue_b_we_i, funct3: issue_b_funct3_i, boff: issue_b_boff_i};

  always_comb begin
    oh_a = '0; oh_b = '0; toh_a = '0; toh_b = '0;
    for (int c = 0; c < NCORES; c++) begin
      oh_a[c]  = (issue_a_sel_i == SELW'(c));
      oh_b[c]  = (issue_b_sel_i == SELW'(c));
      toh_a[c] = (tail_sel_a == SELW'(c));
      toh_b[c] = (tail_sel_b == SELW'(c));
    end
  end

  // Out-of-range selects match no core; on a same-core collision lane A wins.
  assign ok_a    = |oh_a;
  assign ok_b    = |oh_b;
  assign collide = issue_a_valid_i & issue_b_valid_i & (issue_a_sel_i == issue_b_sel_i);
  assign cap_a   = issue_a_valid_i & ok_a;
  assign cap_b   = issue_b_valid_i & ok_b & ~collide;

  resp_tag_pipe #(.DEPTH(MEM_LATENCY), .TAGW(TAGW), .SELW(SELW)) u_pipe_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(cap_a), .in_tag_i({issue_a_sel_i, acc_a}),
    .valid_o(pv_a), .sel_o(ps_a), .tail_valid_o(tail_v_a), .tail_tag_o(tail_tag_a)
  );

  resp_tag_pipe #(.DEPTH(MEM_LATENCY), .TAGW(TAGW), .SELW(SELW)) u_pipe_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(cap_b), .in_tag_i({issue_b_sel_i, acc_b}),
    .valid_o(pv_b), .sel_o(ps_b), .tail_valid_o(tail_v_b), .tail_tag_o(tail_tag_b)
  );

  assign {tail_sel_a, tail_acc_a} = tail_tag_a;
  assign {tail_sel_b, tail_acc_b} = tail_tag_b;

  always_comb begin
    busy = rsp_valid_q;
    for (int c = 0; c < NCORES; c++) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        if (pv_a[i] && ps_a[i*SELW +: SELW] == SELW'(c)) busy[c] = 1'b1;
        if (pv_b[i] && ps_b[i*SELW +: SELW] == SELW'(c)) busy[c] = 1'b1;
      end
    end
  end

`ifdef RESP_LOAD_EXT_EN
  function automatic logic [DATA_WIDTH-1:0] fmt_load(input logic [DATA_WIDTH-1:0] w,
                                                     input logic [2:0] f3, input logic [1:0] boff);
    logic [DATA_WIDTH-1:0] s;
    s = w >> {boff, 3'b000};
    case (f3)
      F3_LB:   fmt_load = {{(DATA_WIDTH-8){s[7]}}, s[7:0]};
      F3_LH:   fmt_load = {{(DATA_WIDTH-16){s[15]}}, s[15:0]};
      F3_LW:   fmt_load = s;
      F3_LBU:  fmt_load = {{(DATA_WIDTH-8){1'b0}}, s[7:0]};
      F3_LHU:  fmt_load = {{(DATA_WIDTH-16){1'b0}}, s[15:0]};
      default: fmt_load = w;
    endcase
  endfunction

  assign resp_a = tail_acc_a.we ? '0 : fmt_load(mem_rdata_a_i, tail_acc_a.funct3, tail_acc_a.boff);
  assign resp_b = tail_acc_b.we ? '0 : fmt_load(mem_rdata_b_i, tail_acc_b.funct3, tail_acc_b.boff);
`else
  logic unused_fmt;
  assign unused_fmt = ^{tail_acc_a.funct3, tail_acc_a.boff, tail_acc_b.funct3, tail_acc_b.boff};
  assign resp_a     = tail_acc_a.we ? '0 : mem_rdata_a_i;
  assign resp_b     = tail_acc_b.we ? '0 : mem_rdata_b_i;
`endif

  always_comb begin
    rsp_valid_d = '0;
    rdata_d     = rdata_q;
    for (int c = 0; c < NCORES; c++) begin
      if (tail_v_a && toh_a[c]) begin
        rsp_valid_d[c]                     = 1'b1;
        rdata_d[c*DATA_WIDTH +: DATA_WIDTH] = resp_a;
      end
      if (tail_v_b && toh_b[c]) begin
        rsp_valid_d[c]                     = 1'b1;
        rdata_d[c*DATA_WIDTH +: DATA_WIDTH] = resp_b;
      end
    end
  end

  assign err_d = err_q | collide
               | (issue_a_valid_i & ~ok_a) | (issue_b_valid_i & ~ok_b)
               | (cap_a & |(oh_a & busy)) | (issue_b_valid_i & ok_b & |(oh_b & busy));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid_o        = rsp_valid_q;
  assign rsp_rdata_packed_o = rdata_q;
  assign busy_o             = busy;
  assign err_o              = err_q;
endmodule

// File: tb/tb_dmem_resp_router.sv
// tb/tb_dmem_resp_router.sv - two routers (latency 1 and 3) on shared issue stimulus, scoreboard-checked
module tb_dmem_resp_router;
  localparam int NC   = 4;
  localparam int DW   = 32;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int BIG  = 32'h7fff_ffff;
`ifdef RESP_LOAD_EXT_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  typedef struct {
    int          due;
    int          dut;
    int          core;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic a_v; logic [1:0] a_sel; logic a_we; logic [2:0] a_f3; logic [1:0] a_bo; logic [31:0] a_d;
    logic [31:0] a_xe; logic [31:0] a_xr;
    logic b_v; logic [1:0] b_sel; logic b_we; logic [2:0] b_f3; logic [1:0] b_bo; logic [31:0] b_d;
    logic [31:0] b_xe; logic [31:0] b_xr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic a_v, a_we, b_v, b_we;
  logic [1:0] a_sel, a_bo, b_sel, b_bo;
  logic [2:0] a_f3, b_f3;
  logic [31:0] din_a, din_b;
  logic [31:0] dl_a [4];
  logic [31:0] dl_b [4];
  logic [NC-1:0] rv [2];
  logic [NC-1:0] bz [2];
  logic [NC*DW-1:0] rd [2];
  logic er [2];

  exp_t sbq[$];
  logic [31:0] exp_slot [2][NC];
  int err_at [2];
  int errs = 0;
  int checks = 0;

  // Memory model: the word presented at issue time comes back LAT cycles later.
  always @(posedge clk) begin
    dl_a[0] <= din_a;
    dl_b[0] <= din_b;
    for (int i = 1; i < 4; i++) begin
      dl_a[i] <= dl_a[i-1];
      dl_b[i] <= dl_b[i-1];
    end
  end

  dmem_resp_router #(.NCORES(NC), .ADDR_WIDTH(16), .DATA_WIDTH(DW), .MEM_LATENCY(LAT0)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_a_valid_i(a_v), .issue_a_sel_i(a_sel), .issue_a_we_i(a_we),
    .issue_a_funct3_i(a_f3), .issue_a_boff_i(a_bo),
    .issue_b_valid_i(b_v), .issue_b_sel_i(b_sel), .issue_b_we_i(b_we),
    .issue_b_funct3_i(b_f3), .issue_b_boff_i(b_bo),
    .mem_rdata_a_i(dl_a[LAT0-1]), .mem_rdata_b_i(dl_b[LAT0-1]),
    .rsp_valid_o(rv[0]), .rsp_rdata_packed_o(rd[0]), .busy_o(bz[0]), .err_o(er[0])
  );

  dmem_resp_router #(.NCORES(NC), .ADDR_WIDTH(16), .DATA_WIDTH(DW), .MEM_LATENCY(LAT1)) u_l3 (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_a_valid_i(a_v), .issue_a_sel_i(a_sel), .issue_a_we_i(a_we),
    .issue_a_funct3_i(a_f3), .issue_a_boff_i(a_bo),
    .issue_b_valid_i(b_v), .issue_b_sel_i(b_sel), .issue_b_we_i(b_we),
    .issue_b_funct3_i(b_f3), .issue_b_boff_i(b_bo),
    .mem_rdata_a_i(dl_a[LAT1-1]), .mem_rdata_b_i(dl_b[LAT1-1]),
    .rsp_valid_o(rv[1]), .rsp_rdata_packed_o(rd[1]), .busy_o(bz[1]), .err_o(er[1])
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [31:0] model_fmt(input logic [2:0] f3, input logic [1:0] bo, input logic [31:0] d);
    logic [63:0] wide;
    logic [7:0]  b8;
    logic [15:0] h16;
    wide = {32'h0, d};
    b8   = wide[bo*8 +: 8];
    h16  = wide[bo*8 +: 16];
    case (f3)
      3'b000:  return {{24{b8[7]}}, b8};
      3'b001:  return {{16{h16[15]}}, h16};
      3'b010:  return wide[bo*8 +: 32];
      3'b100:  return {24'h0, b8};
      3'b101:  return {16'h0, h16};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_of(input logic we, input logic [2:0] f3, input logic [1:0] bo,
                                         input logic [31:0] d);
    if (we) return 32'h0;
    return EXT ? model_fmt(f3, bo, d) : d;
  endfunction

  function automatic bit mbusy(input int d, input int core);
    foreach (sbq[i])
      if (sbq[i].dut == d && sbq[i].core == core &&
          sbq[i].due - lat_of(d) <= cyc && cyc <= sbq[i].due) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string nm, input int d, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d cyc%0d: got %h expected %h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    a_v = 1'b0; a_sel = 2'($urandom); a_we = 1'($urandom); a_f3 = 3'($urandom); a_bo = 2'($urandom);
    b_v = 1'b0; b_sel = 2'($urandom); b_we = 1'($urandom); b_f3 = 3'($urandom); b_bo = 2'($urandom);
    din_a = $urandom;
    din_b = $urandom;
  endtask

  task automatic drive(input vec_t v);
    bit coll;
    a_v = v.a_v; a_sel = v.a_sel; a_we = v.a_we; a_f3 = v.a_f3; a_bo = v.a_bo; din_a = v.a_d;
    b_v = v.b_v; b_sel = v.b_sel; b_we = v.b_we; b_f3 = v.b_f3; b_bo = v.b_bo; din_b = v.b_d;
    coll = v.a_v && v.b_v && (v.a_sel == v.b_sel);
    for (int d = 0; d < 2; d++) begin
      if (coll || (v.a_v && mbusy(d, int'(v.a_sel))) || (v.b_v && mbusy(d, int'(v.b_sel))))
        if (err_at[d] > cyc + 1) err_at[d] = cyc + 1;
    end
    for (int d = 0; d < 2; d++) begin
      if (v.a_v) sbq.push_back('{cyc + lat_of(d) + 1, d, int'(v.a_sel), EXT ? v.a_xe : v.a_xr});
      if (v.b_v && !coll) sbq.push_back('{cyc + lat_of(d) + 1, d, int'(v.b_sel), EXT ? v.b_xe : v.b_xr});
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [1:0] as, input logic awe, input logic [2:0] af,
                              input logic [1:0] ab, input logic [31:0] ad,
                              input logic bv, input logic [1:0] bs, input logic bwe, input logic [2:0] bf,
                              input logic [1:0] bb, input logic [31:0] bd);
    vec_t v;
    v = '{av, as, awe, af, ab, ad, 32'h0, 32'h0, bv, bs, bwe, bf, bb, bd, 32'h0, 32'h0};
    v.a_xe = awe ? 32'h0 : model_fmt(af, ab, ad);
    v.a_xr = awe ? 32'h0 : ad;
    v.b_xe = bwe ? 32'h0 : model_fmt(bf, bb, bd);
    v.b_xr = bwe ? 32'h0 : bd;
    return v;
  endfunction

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    sbq.delete();
    err_at = '{BIG, BIG};
    for (int d = 0; d < 2; d++) for (int c = 0; c < NC; c++) exp_slot[d][c] = '0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    logic [NC-1:0] ev, eb;
    logic [NC*DW-1:0] ed;
    for (int d = 0; d < 2; d++) begin
      ev = '0;
      eb = '0;
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].dut == d) begin
          if (sbq[i].due - lat_of(d) <= cyc && cyc <= sbq[i].due) eb[sbq[i].core] = 1'b1;
          if (sbq[i].due == cyc) begin
            ev[sbq[i].core] = 1'b1;
            exp_slot[d][sbq[i].core] = sbq[i].data;
            sbq.delete(i);
          end
        end
      end
      for (int c = 0; c < NC; c++) ed[c*DW +: DW] = exp_slot[d][c];
      chk("rsp_valid", d, 128'(rv[d]), 128'(ev));
      chk("rsp_rdata", d, 128'(rd[d]), 128'(ed));
      chk("busy", d, 128'(bz[d]), 128'(eb));
      chk("err", d, 128'(er[d]), 128'(cyc >= err_at[d]));
    end
  end

  vec_t tbl [7];

  initial begin
    // Expected fields: {a_xe, a_xr} / {b_xe, b_xr} are hand-derived (extended, raw).
    tbl[0] = '{1, 2, 0, 3'b010, 0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF,
               0, 0, 0, 3'b010, 0, 32'h0,        32'h0,        32'h0};
    tbl[1] = '{1, 0, 0, 3'b010, 0, 32'h12345678, 32'h12345678, 32'h12345678,
               1, 3, 1, 3'b010, 0, 32'hAAAA5555, 32'h0,        32'h0};
    tbl[2] = '{1, 1, 0, 3'b000, 3, 32'h80123456, 32'hFFFFFF80, 32'h80123456,
               1, 0, 0, 3'b101, 2, 32'h80123456, 32'h00008012, 32'h80123456};
    tbl[3] = '{1, 3, 0, 3'b100, 1, 32'h1234F078, 32'h000000F0, 32'h1234F078,
               1, 2, 0, 3'b001, 0, 32'h00008001, 32'hFFFF8001, 32'h00008001};
    tbl[4] = '{1, 1, 1, 3'b010, 0, 32'h55555555, 32'h0,        32'h0,
               1, 2, 0, 3'b011, 1, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D};
    tbl[5] = '{0, 0, 0, 3'b010, 0, 32'h0,        32'h0,        32'h0,
               1, 1, 0, 3'b010, 0, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D};
    tbl[6] = '{1, 0, 0, 3'b000, 0, 32'h0000007F, 32'h0000007F, 32'h0000007F,
               1, 1, 0, 3'b001, 2, 32'h7FFF0000, 32'h00007FFF, 32'h7FFF0000};

    a_v = 1'b0; b_v = 1'b0;
    a_sel = '0; a_we = 1'b0; a_f3 = '0; a_bo = '0;
    b_sel = '0; b_we = 1'b0; b_f3 = '0; b_bo = '0;
    din_a = '0; din_b = '0;
    do_reset(3);
    step();

    foreach (tbl[i]) begin
      drive(tbl[i]);
      repeat (7) step();
    end

    // Second issue to core 1 while its first access is still in flight.
    drive(mk(1, 1, 0, 3'b010, 0, 32'h0A0A0A0A, 0, 0, 0, 3'b010, 0, 32'h0));
    step();
    drive(mk(1, 1, 0, 3'b000, 1, 32'h0000C300, 0, 0, 0, 3'b010, 0, 32'h0));
    repeat (8) step();
    do_reset(2);
    repeat (3) step();

    // Both lanes claim core 1: only lane A responds, error sticks.
    drive(mk(1, 1, 0, 3'b010, 0, 32'h11112222, 1, 1, 0, 3'b010, 0, 32'h33334444));
    repeat (15) step();
    do_reset(2);
    step();

    for (int i = 0; i < 20; i++) begin
      logic [2:0] f3;
      logic [1:0] bo;
      logic [31:0] da, db;
      f3 = 3'($urandom); bo = 2'($urandom); da = $urandom; db = $urandom;
      drive(mk(1, 2'(i % 2), 0, 3'b010, 0, da, 1, 2'(2 + i % 2), 0, f3, bo, db));
      step();
    end
    repeat (8) step();

    // Reset while entries are still in the pipelines.
    drive(mk(1, 0, 0, 3'b010, 0, 32'hFEEDFACE, 1, 3, 0, 3'b010, 0, 32'hBEEFCAFE));
    step();
    drive(mk(1, 1, 0, 3'b010, 0, 32'h01020304, 0, 0, 0, 3'b010, 0, 32'h0));
    step();
    do_reset(2);
    repeat (10) step();

    chk("scoreboard_drained", 0, 128'(sbq.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
